// File: rtl/iterative_alu_exec.sv
// -----------------------------------------------------------------------------
// iterative_alu_exec
//
// Execute-stage ALU driven by the 3-bit aluOP from decode. ADD, SUB, AND, OR,
// XOR, NOT and DIV-by-zero finish in one cycle. MUL (shift-add) and DIV
// (unsigned restoring) take one operand bit per cycle for WIDTH cycles.
//
// Handshake: start is sampled only on an edge where busy=0. That edge accepts
// the op and latches a/b. done is a registered one-cycle pulse that marks
// result/zero/neg/div_by_zero as valid. The outputs then hold until the next
// done. start may be high in the same cycle as done, so the next op is
// accepted on that edge. A start seen while busy=1 is dropped, not queued.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset, abandons any in-flight op
//   start        op request
//   aluOP        000 ADD 001 SUB 010 MUL 011 DIV 100 AND 101 OR 110 XOR 111 NOT
//   a, b         operands (dividend/multiplicand, divisor/multiplier)
//   busy         MUL/DIV iteration in progress
//   done         one-cycle result-valid pulse
//   result       registered result
//   zero, neg    result==0 and result MSB, registered with result
//   div_by_zero  DIV with b==0, refreshed on every done
//   dbg_state_o  current FSM state (0 IDLE, 1 MUL, 2 DIV)
// -----------------------------------------------------------------------------
module iterative_alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       aluOP,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // MUL: opa = shifted multiplicand, opb = shifted multiplier, acc = product.
    // DIV: opa = dividend shifting out / quotient shifting in, opb = divisor,
    //      acc = partial remainder (always < divisor, so it fits WIDTH bits).
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    // Combinational helpers
    logic             fin;
    logic [WIDTH-1:0] res_n;
    logic             dbz_n;
    logic             last_iter;
    logic [WIDTH-1:0] prod;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             qbit;

    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            dbz_q    <= dbz_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        result_d  = result_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        fin       = 1'b0;
        res_n     = result_q;
        dbz_n     = 1'b0;
        prod      = '0;
        rem_shift = '0;
        rem_diff  = '0;
        qbit      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (aluOP)
                        OP_ADD: begin res_n = a + b;  fin = 1'b1; end
                        OP_SUB: begin res_n = a - b;  fin = 1'b1; end
                        OP_AND: begin res_n = a & b;  fin = 1'b1; end
                        OP_OR:  begin res_n = a | b;  fin = 1'b1; end
                        OP_XOR: begin res_n = a ^ b;  fin = 1'b1; end
                        OP_NOT: begin res_n = ~a;     fin = 1'b1; end
                        OP_MUL: begin
                            opa_d   = a;
                            opb_d   = b;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = S_MUL;
                        end
                        OP_DIV: begin
                            if (b == '0) begin
                                // Divide by zero short-circuits to all ones.
                                res_n = '1;
                                dbz_n = 1'b1;
                                fin   = 1'b1;
                            end else begin
                                opa_d   = a;
                                opb_d   = b;
                                acc_d   = '0;
                                cnt_d   = '0;
                                state_d = S_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            S_MUL: begin
                // Add the multiplicand when the current multiplier LSB is set.
                // Bits shifted past the MSB are dropped, so only the low
                // WIDTH bits of the product are kept.
                prod  = acc_q + (opb_q[0] ? opa_q : '0);
                acc_d = prod;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    res_n   = prod;
                    fin     = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_DIV: begin
                // Bring down the next dividend bit. Subtract the divisor when
                // it fits, and shift the quotient bit into opa.
                rem_shift = {acc_q, opa_q[WIDTH-1]};
                rem_diff  = rem_shift - {1'b0, opb_q};
                qbit      = (rem_shift >= {1'b0, opb_q});
                acc_d     = qbit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                opa_d     = {opa_q[WIDTH-2:0], qbit};
                cnt_d     = cnt_q + 1'b1;
                if (last_iter) begin
                    res_n   = {opa_q[WIDTH-2:0], qbit};
                    fin     = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (fin) begin
            result_d = res_n;
            zero_d   = (res_n == '0);
            neg_d    = res_n[WIDTH-1];
            dbz_d    = dbz_n;
            done_d   = 1'b1;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign result      = result_q;
    assign zero        = zero_q;
    assign neg         = neg_q;
    assign div_by_zero = dbz_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/iterative_alu_exec.md
Name: iterative_alu_exec

Overview:
- Execute-stage ALU that consumes the 3-bit aluOP produced by the decode-side opcode translation and performs the operation with a start/done handshake.
- ADD/SUB/AND/OR/XOR/NOT complete in one cycle. MUL and DIV are iterative, one bit per cycle.
- Sits between decode/register-read and writeback. The pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand and result width in bits (integer, at least 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only when busy=0.
- aluOP  input  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 NOT.
- a  input  WIDTH  operand A (dividend / multiplicand).
- b  input  WIDTH  operand B (divisor / multiplier); ignored for NOT.
- busy  output  1  high while a MUL/DIV iteration is in progress.
- done  output  1  one-cycle pulse; result and flags valid from this cycle.
- result  output  WIDTH  registered result; held until the next done.
- zero  output  1  result == 0, registered with result.
- neg  output  1  result[WIDTH-1], registered with result.
- div_by_zero  output  1  set with done for DIV with b==0; cleared at the next done.

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE; busy=0, done=0, result=0, zero=0, neg=0, div_by_zero=0.
  - Iteration counter and internal registers cleared.
  - rst takes priority over start and over any in-flight op; the op is abandoned and no done is issued.
- States: IDLE, MUL, DIV.
- IDLE, start=1, aluOP in {ADD, SUB, AND, OR, XOR, NOT}:
  - result computed and registered at that edge; done=1 the following cycle (latency 1); stay IDLE.
  - ADD/SUB wrap modulo 2^WIDTH; no carry/overflow output.
  - NOT yields ~a.
- IDLE, start=1, aluOP=MUL:
  - Latch a and b; counter=0; go to MUL; busy=1 from the next cycle.
  - Shift-add over WIDTH cycles. Result = low WIDTH bits of unsigned a*b.
  - On the edge of the final iteration: result/flags updated, busy=0, done=1, state=IDLE.
  - start-to-done latency = WIDTH+1 cycles. done is high in the cycle where busy drops.
- IDLE, start=1, aluOP=DIV, b != 0:
  - Unsigned restoring division over WIDTH cycles; result = floor(a/b).
  - Remainder is internal only.
  - Same latency and handshake as MUL.
- IDLE, start=1, aluOP=DIV, b == 0:
  - No iteration; result = all ones, div_by_zero=1, done=1 after 1 cycle (single-cycle path).
- start while busy=1: ignored, no queuing. Operand changes while busy are ignored because operands are latched.
- Back-to-back: start may be asserted in the same cycle done=1. The new op is accepted that edge, so 1-cycle ops produce done every cycle.
- done is never high for more than one cycle per accepted start.
- result, zero, neg and div_by_zero change only on a done-producing edge or on reset.
- Counter width is clog2(WIDTH)+1; no wrap beyond WIDTH iterations.

Test Plan:
- Reset: rst=1 for 2 cycles mid-MUL (busy=1) -> busy=0, done=0, result=0, all flags 0; no late done.
- Single-cycle ops, WIDTH=32:
  - ADD 0xFFFFFFFF+1 -> result 0, zero=1, done one cycle after start.
  - SUB 3-5 -> 0xFFFFFFFE, neg=1.
  - XOR 0xF0F0F0F0^0xFFFF0000 -> 0x0F0FF0F0.
  - NOT a=0 -> 0xFFFFFFFF.
- MUL 0x00012345 * 0x00000100:
  - result 0x01234500.
  - busy high for 32 cycles, done at cycle 33 after start.
  - Second start during busy is ignored.
- DIV:
  - 100/7 -> result 14, latency 33.
  - 0xFFFFFFFF/1 -> 0xFFFFFFFF.
  - 5/9 -> 0, zero=1.
- DIV by zero: a=42, b=0 -> result 0xFFFFFFFF, div_by_zero=1, done after 1 cycle. Next ADD 1+1 -> result 2, div_by_zero=0.
- Back-to-back: start held high for 4 cycles with ADD, AND, OR, ADD -> done high 4 consecutive cycles, results in order.
